// File: rtl/crack_pkg.sv
// Shared types and constants for the crack-core result collector.
package crack_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RST_CORES = 3'd1,
        WAIT_RDY  = 3'd2,
        KICK      = 3'd3,
        RUN       = 3'd4,
        FOUND     = 3'd5,
        FAILED    = 3'd6
    } state_t;

    localparam int         KEY_W     = 24;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to active-low seven-segment pattern (bit 6 = g ... bit 0 = a).
module hex_to_7seg (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_nibble)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/crack_collector.sv
// Launches a bank of crack cores, latches the first reported key or declares
// failure once every core has finished, and shows the outcome on six displays.
module crack_collector
    import crack_pkg::*;
#(
    parameter int NCORES = 2,
    parameter int CYC_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      core_rst_n,
    output logic [NCORES-1:0]         core_en,
    input  logic [NCORES-1:0]         core_rdy,
    input  logic [KEY_W*NCORES-1:0]   core_key,
    input  logic [NCORES-1:0]         core_key_valid,
    output logic [KEY_W-1:0]          key,
    output logic                      found,
    output logic                      failed,
    output logic                      busy,
    output logic [CYC_W-1:0]          cycles,
    output logic [6:0]                hex0,
    output logic [6:0]                hex1,
    output logic [6:0]                hex2,
    output logic [6:0]                hex3,
    output logic [6:0]                hex4,
    output logic [6:0]                hex5
);

    state_t              r_state;
    state_t              w_state_next;
    logic [KEY_W-1:0]    r_key;
    logic [CYC_W-1:0]    r_cycles;
    logic [NCORES-1:0]   r_seen_busy;

    logic                w_any_valid;
    logic                w_all_done;
    logic [KEY_W-1:0]    w_sel_key;
    logic [6:0]          w_digit_seg [6];
    logic [6:0]          w_hex       [6];

    // Descending scan so the lowest valid index is the last (winning) write.
    always_comb begin
        w_sel_key = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (core_key_valid[i]) begin
                w_sel_key = core_key[KEY_W*i +: KEY_W];
            end
        end
    end

    assign w_any_valid = |core_key_valid;
    assign w_all_done  = (&r_seen_busy) && (&core_rdy);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (start) w_state_next = RST_CORES;
            RST_CORES: w_state_next = WAIT_RDY;
            WAIT_RDY:  if (&core_rdy) w_state_next = KICK;
            KICK:      w_state_next = RUN;
            RUN: begin
                if (w_any_valid) begin
                    w_state_next = FOUND;
                end else if (w_all_done) begin
                    w_state_next = FAILED;
                end
            end
            FOUND:     if (start) w_state_next = RST_CORES;
            FAILED:    if (start) w_state_next = RST_CORES;
            default:   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_key       <= '0;
            r_cycles    <= '0;
            r_seen_busy <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                RST_CORES: begin
                    r_key       <= '0;
                    r_cycles    <= '0;
                    r_seen_busy <= '0;
                end
                RUN: begin
                    r_seen_busy <= r_seen_busy | ~core_rdy;
                    if (r_cycles != {CYC_W{1'b1}}) begin
                        r_cycles <= r_cycles + {{(CYC_W-1){1'b0}}, 1'b1};
                    end
                    if (w_any_valid) begin
                        r_key <= w_sel_key;
                    end
                end
                default: ;
            endcase
        end
    end

    // Cores stay in reset for as long as our own reset is held.
    assign core_rst_n = ~rst && (r_state != RST_CORES);
    assign core_en    = {NCORES{r_state == KICK}};
    assign found      = (r_state == FOUND);
    assign failed     = (r_state == FAILED);
    assign busy       = (r_state == RST_CORES) || (r_state == WAIT_RDY) ||
                        (r_state == KICK)      || (r_state == RUN);
    assign key        = r_key;
    assign cycles     = r_cycles;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            hex_to_7seg u_dec (
                .i_nibble (r_key[4*gi +: 4]),
                .o_seg    (w_digit_seg[gi])
            );
            assign w_hex[gi] = (r_state == FOUND)  ? w_digit_seg[gi] :
                               (r_state == FAILED) ? SEG_DASH        : SEG_BLANK;
        end
    endgenerate

    assign hex0 = w_hex[0];
    assign hex1 = w_hex[1];
    assign hex2 = w_hex[2];
    assign hex3 = w_hex[3];
    assign hex4 = w_hex[4];
    assign hex5 = w_hex[5];

endmodule

// File: tb/tb_crack_collector.sv
// Directed and randomized bench for crack_collector with two stub cores driven by the bench.
module tb_crack_collector;

    localparam int NC = 2;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              core_rst_n;
    logic [NC-1:0]     core_en;
    logic [NC-1:0]     core_rdy;
    logic [24*NC-1:0]  core_key;
    logic [NC-1:0]     core_key_valid;
    logic [23:0]       key;
    logic              found;
    logic              failed;
    logic              busy;
    logic [CW-1:0]     cycles;
    logic [6:0]        hex0, hex1, hex2, hex3, hex4, hex5;
    logic [6:0]        hx [6];

    int checks = 0;
    int errors = 0;

    // Standard active-low hex digit patterns, index = digit value.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    crack_collector #(.NCORES(NC), .CYC_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .core_rst_n     (core_rst_n),
        .core_en        (core_en),
        .core_rdy       (core_rdy),
        .core_key       (core_key),
        .core_key_valid (core_key_valid),
        .key            (key),
        .found          (found),
        .failed         (failed),
        .busy           (busy),
        .cycles         (cycles),
        .hex0           (hex0),
        .hex1           (hex1),
        .hex2           (hex2),
        .hex3           (hex3),
        .hex4           (hex4),
        .hex5           (hex5)
    );

    always #5 clk = ~clk;

    assign hx[0] = hex0;
    assign hx[1] = hex1;
    assign hx[2] = hex2;
    assign hx[3] = hex3;
    assign hx[4] = hex4;
    assign hx[5] = hex5;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: blank, 1: digits of k, 2: dashes
    task automatic check_disp(input string tag, input int mode, input logic [23:0] k);
        logic [6:0] e;
        logic [3:0] nib;
        for (int i = 0; i < 6; i++) begin
            nib = k[4*i +: 4];
            e = (mode == 1) ? seg_tab[nib] : (mode == 2) ? 7'b0111111 : 7'h7F;
            chk($sformatf("%s_hex%0d", tag, i), {41'd0, hx[i]}, {41'd0, e});
        end
    endtask

    // Start a search; cores report not-ready for 'hold' cycles in WAIT_RDY.
    // Returns with the DUT in its first RUN cycle.
    task automatic launch(input int hold);
        core_key_valid = '0;
        core_rdy = (hold > 0) ? '0 : '1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("launch_rst_n_low", {47'd0, core_rst_n}, 48'd0);
        chk("launch_busy", {47'd0, busy}, 48'd1);
        step();
        chk("launch_rst_n_one_cycle", {47'd0, core_rst_n}, 48'd1);
        for (int i = 0; i < hold; i++) begin
            chk("launch_wait_no_en", {46'd0, core_en}, 48'd0);
            step();
        end
        core_rdy = '1;
        step();
        chk("launch_kick_en", {46'd0, core_en}, 48'd3);
        chk("launch_kick_cycles", {16'd0, cycles}, 48'd0);
        chk("launch_kick_key", {24'd0, key}, 48'd0);
        step();
        chk("launch_en_one_cycle", {46'd0, core_en}, 48'd0);
        chk("launch_run_busy", {47'd0, busy}, 48'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b1;
        core_rdy = '1;
        core_key = '0;
        core_key_valid = '0;
        step();
        chk("rst_core_rst_n", {47'd0, core_rst_n}, 48'd0);
        step();
        rst = 1'b0;
        start = 1'b0;
        chk("rst_key", {24'd0, key}, 48'd0);
        chk("rst_found", {47'd0, found}, 48'd0);
        chk("rst_failed", {47'd0, failed}, 48'd0);
        chk("rst_busy", {47'd0, busy}, 48'd0);
        chk("rst_cycles", {16'd0, cycles}, 48'd0);
        chk("rst_core_en", {46'd0, core_en}, 48'd0);
        check_disp("rst", 0, 24'd0);
        step();
        chk("idle_rst_n", {47'd0, core_rst_n}, 48'd1);
        chk("lost_start_busy", {47'd0, busy}, 48'd0);

        // Found at RUN cycle 40 by core 1; start pulses during RUN are ignored.
        launch(0);
        for (int c = 1; c < 40; c++) begin
            start = (c == 5);
            step();
            if (c == 5) begin
                chk("run_start_ignored_rst_n", {47'd0, core_rst_n}, 48'd1);
                chk("run_start_ignored_busy", {47'd0, busy}, 48'd1);
            end
        end
        start = 1'b0;
        core_key_valid = 2'b10;
        core_key = {24'h00001B, 24'h000000};
        step();
        core_key_valid = '0;
        chk("found40_found", {47'd0, found}, 48'd1);
        chk("found40_key", {24'd0, key}, 48'h1B);
        chk("found40_cycles", {16'd0, cycles}, 48'd40);
        chk("found40_busy", {47'd0, busy}, 48'd0);
        check_disp("found40", 1, 24'h00001B);
        core_key_valid = 2'b01;
        core_key = {24'h000000, 24'h777777};
        step();
        core_key_valid = '0;
        chk("late_finder_key", {24'd0, key}, 48'h1B);
        chk("frozen_cycles", {16'd0, cycles}, 48'd40);

        // Simultaneous finders: lowest index wins; a later finder changes nothing.
        launch(2);
        core_key_valid = 2'b11;
        core_key = {24'h000011, 24'h000010};
        step();
        core_key_valid = 2'b10;
        core_key = {24'h000022, 24'h000000};
        chk("simul_key", {24'd0, key}, 48'h10);
        step();
        core_key_valid = '0;
        chk("simul_late_key", {24'd0, key}, 48'h10);
        chk("simul_found", {47'd0, found}, 48'd1);

        // Failure: both cores run and finish without a key.
        launch(0);
        core_rdy = 2'b00;
        step();
        core_rdy = 2'b11;
        step();
        chk("fail_failed", {47'd0, failed}, 48'd1);
        chk("fail_found", {47'd0, found}, 48'd0);
        chk("fail_cycles", {16'd0, cycles}, 48'd2);
        check_disp("fail", 2, 24'd0);

        // Valid beats the all-done check in the same cycle.
        launch(1);
        core_rdy = 2'b00;
        step();
        core_rdy = 2'b11;
        core_key_valid = 2'b10;
        core_key = {24'hABCDEF, 24'h000000};
        step();
        core_key_valid = '0;
        chk("vbd_found", {47'd0, found}, 48'd1);
        chk("vbd_failed", {47'd0, failed}, 48'd0);
        chk("vbd_key", {24'd0, key}, 48'hABCDEF);
        check_disp("vbd", 1, 24'hABCDEF);

        // Randomized searches against an outcome model: each core goes busy on the
        // first RUN cycle and finishes at cycle t; finders report on their finish cycle.
        for (int tr = 0; tr < 12; tr++) begin
            int          t   [NC];
            bit          fnd [NC];
            logic [23:0] kv  [NC];
            int          dc;
            bit          anyf;
            logic [23:0] ek;
            anyf = 1'b0;
            dc = 0;
            ek = 24'd0;
            for (int i = 0; i < NC; i++) begin
                t[i]   = int'($urandom_range(2, 30));
                fnd[i] = ($urandom_range(0, 2) == 0);
                kv[i]  = 24'($urandom);
                if (fnd[i] && (!anyf || t[i] < dc)) begin
                    anyf = 1'b1;
                    dc = t[i];
                    ek = kv[i];
                end
            end
            if (!anyf) begin
                for (int i = 0; i < NC; i++) dc = (t[i] > dc) ? t[i] : dc;
            end
            launch(int'($urandom_range(0, 3)));
            for (int c = 1; c <= dc; c++) begin
                for (int i = 0; i < NC; i++) begin
                    core_rdy[i]       = (c >= t[i]);
                    core_key_valid[i] = fnd[i] && (c == t[i]);
                    core_key[24*i +: 24] = core_key_valid[i] ? kv[i] : 24'($urandom);
                end
                start = (c == 1);
                step();
            end
            start = 1'b0;
            core_key_valid = '0;
            chk($sformatf("rnd%0d_found", tr), {47'd0, found}, {47'd0, anyf});
            chk($sformatf("rnd%0d_failed", tr), {47'd0, failed}, {47'd0, !anyf});
            chk($sformatf("rnd%0d_key", tr), {24'd0, key}, {24'd0, ek});
            chk($sformatf("rnd%0d_cycles", tr), {16'd0, cycles}, 48'(dc));
            check_disp($sformatf("rnd%0d", tr), anyf ? 1 : 2, ek);
        end

        // Reset in the middle of a search.
        launch(0);
        for (int c = 1; c <= 5; c++) step();
        rst = 1'b1;
        #1;
        chk("midrst_rst_n_now", {47'd0, core_rst_n}, 48'd0);
        step();
        chk("midrst_rst_n_held", {47'd0, core_rst_n}, 48'd0);
        chk("midrst_busy", {47'd0, busy}, 48'd0);
        chk("midrst_cycles", {16'd0, cycles}, 48'd0);
        chk("midrst_key", {24'd0, key}, 48'd0);
        check_disp("midrst", 0, 24'd0);
        rst = 1'b0;
        step();
        chk("midrst_release_rst_n", {47'd0, core_rst_n}, 48'd1);
        chk("midrst_idle_busy", {47'd0, busy}, 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
